uart_input_word_buffer: RTL and testbench

- Upstream stage of the CPU's READI/READF path.
- Receives bytes from UART_RX and assembles each group of 4 bytes (MSB first) into a 32-bit word.
- Appends each word to an input buffer and publishes a monotonic valid-word count.
- The CPU compares its own read index against that count, stalls while no word is available, and reads words by index.

---
 rtl/uart_input_word_buffer.sv | 179 +++++++++++++++++
 tb/tb_uart_input_word_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/uart_input_word_buffer.sv
// UART receiver that packs 4 bytes (MSB first) into 32-bit words in a write-once buffer.
// Optional even-parity bit per byte when INPUT_PARITY_EN is defined (default: 8N1).
module uart_input_word_buffer #(
  parameter int unsigned CLK_PER_BIT = 868,
  parameter int unsigned LOG_DEPTH   = 10,
  parameter int unsigned DEPTH       = 1 << LOG_DEPTH
) (
  input  logic                 CLK,
  input  logic                 INITIALIZE,
  input  logic                 UART_RX,
  input  logic [LOG_DEPTH-1:0] rd_addr,
  output logic [31:0]          rd_data,
  output logic [LOG_DEPTH:0]   valid_num,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overflow
);

  localparam int unsigned BAUD_W = $clog2(CLK_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } state_t;

  state_t              r_state;
  logic                r_rx_meta;
  logic                r_rx_s;
  logic                r_rx_prev;
  logic [BAUD_W-1:0]   r_baud;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic [23:0]         r_word;
  logic [1:0]          r_byte_idx;
  logic [LOG_DEPTH:0]  r_valid_num;
  logic                r_frame_err;
  logic                r_overflow;
  logic                r_par_bad;
  logic [31:0]         r_mem [DEPTH];
`ifdef INPUT_PARITY_EN
  logic                r_parity_err;
`endif

  logic        w_start;
  logic        w_full;
  logic        w_word_done;
  logic        w_wr_en;
  logic [31:0] w_new_word;

  assign w_start     = r_rx_prev & ~r_rx_s;
  assign w_full      = (r_valid_num >= (LOG_DEPTH+1)'(DEPTH));
  assign w_new_word  = {r_word, r_shift};
  // Word completes on the stop-bit sample of an accepted 4th byte.
  assign w_word_done = (r_state == ST_STOP) && (r_baud == '0) && r_rx_s &&
                       !r_par_bad && (r_byte_idx == 2'd3);
  assign w_wr_en     = !INITIALIZE && w_word_done && !w_full;

  always_ff @(posedge CLK) begin
    r_rx_meta <= UART_RX;
    r_rx_s    <= r_rx_meta;
  end

  always_ff @(posedge CLK) begin
    if (w_wr_en) r_mem[r_valid_num[LOG_DEPTH-1:0]] <= w_new_word;
  end

  always_ff @(posedge CLK) begin
    if (INITIALIZE) begin
      r_state     <= ST_IDLE;
      r_rx_prev   <= 1'b0;
      r_baud      <= '0;
      r_bit       <= '0;
      r_byte_idx  <= '0;
      r_valid_num <= '0;
      r_frame_err <= 1'b0;
      r_overflow  <= 1'b0;
      r_par_bad   <= 1'b0;
`ifdef INPUT_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_prev <= r_rx_s;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_baud    <= BAUD_HALF;
            r_par_bad <= 1'b0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          if (r_baud == '0) begin
            if (!r_rx_s) begin
              r_baud  <= BAUD_FULL;
              r_bit   <= '0;
              r_state <= ST_DATA;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud - BAUD_ONE;
          end
        end
        ST_DATA: begin
          if (r_baud == '0) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
            r_baud  <= BAUD_FULL;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd7) begin
`ifdef INPUT_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end
          end else begin
            r_baud <= r_baud - BAUD_ONE;
          end
        end
`ifdef INPUT_PARITY_EN
        ST_PARITY: begin
          if (r_baud == '0) begin
            r_baud  <= BAUD_FULL;
            r_state <= ST_STOP;
            if ((^r_shift) != r_rx_s) begin
              r_par_bad    <= 1'b1;
              r_parity_err <= 1'b1;
            end
          end else begin
            r_baud <= r_baud - BAUD_ONE;
          end
        end
`endif
        ST_STOP: begin
          if (r_baud == '0) begin
            if (r_rx_s) begin
              r_state <= ST_IDLE;
              if (!r_par_bad) begin
                r_word     <= {r_word[15:0], r_shift};
                r_byte_idx <= r_byte_idx + 2'd1;
                if (r_byte_idx == 2'd3) begin
                  if (!w_full) r_valid_num <= r_valid_num + (LOG_DEPTH+1)'(1);
                  else         r_overflow  <= 1'b1;
                end
              end
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= ST_WAIT_HIGH;
            end
          end else begin
            r_baud <= r_baud - BAUD_ONE;
          end
        end
        ST_WAIT_HIGH: begin
          if (r_rx_s) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_data   = r_mem[rd_addr];
  assign valid_num = r_valid_num;
  assign frame_err = r_frame_err;
  assign overflow  = r_overflow;
`ifdef INPUT_PARITY_EN
  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_input_word_buffer.sv
// Scoreboard bench: stimulus pushes expected words, a monitor checks each new valid word.
module tb_uart_input_word_buffer;

  localparam int unsigned CPB = 16;
  localparam int unsigned LD  = 2;

  logic          CLK = 1'b0;
  logic          INITIALIZE = 1'b1;
  logic          UART_RX = 1'b1;
  logic [LD-1:0] rd_addr = '0;
  logic [31:0]   rd_data;
  logic [LD:0]   valid_num;
  logic          frame_err;
  logic          parity_err;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  uart_input_word_buffer #(.CLK_PER_BIT(CPB), .LOG_DEPTH(LD)) dut (
    .CLK(CLK), .INITIALIZE(INITIALIZE), .UART_RX(UART_RX), .rd_addr(rd_addr),
    .rd_data(rd_data), .valid_num(valid_num), .frame_err(frame_err),
    .parity_err(parity_err), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic idle(input int unsigned n, input logic lvl);
    UART_RX = lvl;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    UART_RX = b;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef INPUT_PARITY_EN
    send_bit((^d) ^ par_flip);
`else
    if (par_flip) $display("note: parity flip ignored in 8N1 build");
`endif
    send_bit(stop);
    idle(4, 1'b1);
  endtask

  task automatic good(input logic [7:0] d);
    send_byte(d, 1'b1, 1'b0);
  endtask

  task automatic do_reset;
    @(negedge CLK);
    INITIALIZE = 1'b1;
    repeat (3) @(negedge CLK);
    INITIALIZE = 1'b0;
    idle(6, UART_RX);
  endtask

  task automatic check_drained(input string name);
    idle(20, UART_RX);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: every new valid_num step must expose the next expected word at valid_num-1.
  initial begin : monitor
    logic [LD:0] last;
    logic [31:0] e;
    last = '0;
    forever begin
      @(negedge CLK);
      if (valid_num < last) begin
        last = valid_num;
      end else if (valid_num > last) begin
        check("valid_num_step", 32'(valid_num), 32'(last) + 32'd1);
        rd_addr = LD'(valid_num - 1'b1);
        #1;
        if (exp_q.size() == 0) begin
          check("unexpected_word", rd_data, 32'hxxxxxxxx);
        end else begin
          e = exp_q.pop_front();
          check("rd_data_word", rd_data, e);
        end
        last = valid_num;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    idle(5, 1'b1);
    INITIALIZE = 1'b0;
    idle(3, 1'b1);
    check("rst_valid_num", 32'(valid_num), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_parity_err", 32'(parity_err), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // Basic word
    exp_q.push_back(32'h12345678);
    good(8'h12); good(8'h34); good(8'h56);
    check("t1_partial_valid", 32'(valid_num), 32'd0);
    good(8'h78);
    check_drained("t1_drained");
    check("t1_valid_num", 32'(valid_num), 32'd1);
    check("t1_frame_err", 32'(frame_err), 32'd0);
    check("t1_overflow", 32'(overflow), 32'd0);

    // Glitch rejected: word is 0xAA plus the next three bytes
    do_reset();
    idle(3, 1'b0);
    idle(30, 1'b1);
    good(8'hAA);
    check("t2_valid_after_aa", 32'(valid_num), 32'd0);
    check("t2_frame_err", 32'(frame_err), 32'd0);
    exp_q.push_back(32'hAABBCCDD);
    good(8'hBB); good(8'hCC); good(8'hDD);
    check_drained("t2_drained");
    check("t2_valid_num", 32'(valid_num), 32'd1);

    // Bad stop bit discards byte without advancing byte index
    do_reset();
    send_byte(8'h55, 1'b0, 1'b0);
    check("t3_frame_err", 32'(frame_err), 32'd1);
    check("t3_valid_after_bad", 32'(valid_num), 32'd0);
    exp_q.push_back(32'h01020304);
    good(8'h01); good(8'h02); good(8'h03); good(8'h04);
    check_drained("t3_drained");
    check("t3_valid_num", 32'(valid_num), 32'd1);

    // Fill and overflow
    do_reset();
    exp_q.push_back(32'h10111213);
    exp_q.push_back(32'h14151617);
    exp_q.push_back(32'h18191A1B);
    exp_q.push_back(32'h1C1D1E1F);
    for (int i = 0; i < 16; i++) good(8'(8'h10 + i));
    check("t4_full_valid", 32'(valid_num), 32'd4);
    check("t4_no_overflow_yet", 32'(overflow), 32'd0);
    for (int i = 16; i < 20; i++) good(8'(8'h10 + i));
    check_drained("t4_drained");
    check("t4_valid_sat", 32'(valid_num), 32'd4);
    check("t4_overflow", 32'(overflow), 32'd1);

    // Reset mid-frame with line held low across release
    do_reset();
    good(8'h11); good(8'h22);
    UART_RX = 1'b0;
    repeat (CPB + CPB/2) @(negedge CLK);
    INITIALIZE = 1'b1;
    repeat (2) @(negedge CLK);
    INITIALIZE = 1'b0;
    idle(40, 1'b0);
    check("t5_valid_after_rst", 32'(valid_num), 32'd0);
    check("t5_frame_err", 32'(frame_err), 32'd0);
    idle(20, 1'b1);
    exp_q.push_back(32'hDEADBEEF);
    good(8'hDE); good(8'hAD); good(8'hBE); good(8'hEF);
    check_drained("t5_drained");
    check("t5_valid_num", 32'(valid_num), 32'd1);
    check("t5_frame_err_end", 32'(frame_err), 32'd0);

`ifdef INPUT_PARITY_EN
    do_reset();
    send_byte(8'h03, 1'b1, 1'b1);
    check("t6_parity_err", 32'(parity_err), 32'd1);
    check("t6_frame_err", 32'(frame_err), 32'd0);
    exp_q.push_back(32'h03A0B0C0);
    good(8'h03); good(8'hA0); good(8'hB0); good(8'hC0);
    check_drained("t6_drained");
    check("t6_valid_num", 32'(valid_num), 32'd1);
`else
    check("t6_parity_tied", 32'(parity_err), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
